y86_regfile_rd: RTL

Parametrised register-file/decode block for the SEQ and pipelined Y-86 datapaths. Derives source and destination register IDs from `icode`/`ra`/`rb`, reads `valA`/`valB` with same-cycle write-back bypass, and accepts two write-back ports (E and M). It also tracks in-flight destinations in a busy scoreboard that raises `stall` on a read-after-write hazard. After reset, an init sequencer loads every register one per cycle, so the array can map to RAM without a per-entry reset.

---
 rtl/y86_regfile_rd.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/y86_regfile_rd.sv
// y86_regfile_rd: Y-86 decode and register-file read stage.
// The block decodes source and destination register IDs from icode/ra/rb and
// reads valA/valB from the register array, with optional same-cycle
// forwarding from the E and M write-back ports. A busy scoreboard raises
// stall on a read-after-write hazard. After reset, an init sequencer
// rewrites every register one per cycle, so the array needs no per-entry
// reset.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   icode, ra, rb, cnd          decoding instruction fields
//   issue                       instruction leaves decode (sets busy bits)
//   dstE_w/valE_w, dstM_w/valM_w write-back ports (ID 4'hF = no write)
//   srcA, srcB, dstE, dstM      decoded register IDs (combinational)
//   valA, valB                  read data (combinational)
//   stall                       hazard or not ready (combinational)
//   ready                       init sequence complete
module y86_regfile_rd #(
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned NREG      = 15,
   parameter logic [3:0]  RSP_ID    = 4'h4,
   parameter int unsigned INIT_MODE = 1,
   parameter int unsigned BYPASS    = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        icode,
   input  logic [3:0]        ra,
   input  logic [3:0]        rb,
   input  logic              cnd,
   input  logic              issue,
   input  logic [3:0]        dstE_w,
   input  logic [3:0]        dstM_w,
   input  logic [DATA_W-1:0] valE_w,
   input  logic [DATA_W-1:0] valM_w,
   output logic [3:0]        srcA,
   output logic [3:0]        srcB,
   output logic [3:0]        dstE,
   output logic [3:0]        dstM,
   output logic [DATA_W-1:0] valA,
   output logic [DATA_W-1:0] valB,
   output logic              stall,
   output logic              ready
);

   localparam int unsigned ID_W  = 4;
   localparam logic [ID_W-1:0] RNONE = 4'hF;
   localparam logic [ID_W-1:0] LAST  = ID_W'(NREG - 1);
   localparam bit BYP = (BYPASS != 0);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   cnt_q, cnt_d;
   logic [NREG-1:0]   busy_q, busy_d;
   logic [DATA_W-1:0] regs_q [NREG];

   logic [DATA_W-1:0] arr_a, arr_b;
   logic              busy_a, busy_b;
   logic              ok_a, ok_b;
   logic              hazard_a, hazard_b;
   logic [DATA_W-1:0] init_val;

   // Register ID decode
   always_comb begin
      srcA = RNONE;
      srcB = RNONE;
      dstE = RNONE;
      dstM = RNONE;
      case (icode)
         4'h2, 4'h4, 4'h6, 4'hA: srcA = ra;
         4'h9, 4'hB:             srcA = RSP_ID;
         default:                srcA = RNONE;
      endcase
      case (icode)
         4'h4, 4'h5, 4'h6:       srcB = rb;
         4'h8, 4'h9, 4'hA, 4'hB: srcB = RSP_ID;
         default:                srcB = RNONE;
      endcase
      case (icode)
         4'h2:                   dstE = cnd ? rb : RNONE;
         4'h3, 4'h6:             dstE = rb;
         4'h8, 4'h9, 4'hA, 4'hB: dstE = RSP_ID;
         default:                dstE = RNONE;
      endcase
      case (icode)
         4'h5, 4'hB:             dstM = ra;
         default:                dstM = RNONE;
      endcase
   end

   // Array and busy lookup; out-of-range IDs (including RNONE) read 0, never busy
   always_comb begin
      arr_a  = '0;
      arr_b  = '0;
      busy_a = 1'b0;
      busy_b = 1'b0;
      for (int i = 0; i < int'(NREG); i++) begin
         if (srcA == ID_W'(i)) begin
            arr_a  = regs_q[i];
            busy_a = busy_q[i];
         end
         if (srcB == ID_W'(i)) begin
            arr_b  = regs_q[i];
            busy_b = busy_q[i];
         end
      end
   end

   // Read mux with M-over-E forwarding; forced to 0 until init completes
   always_comb begin
      ok_a  = (srcA < ID_W'(NREG));
      ok_b  = (srcB < ID_W'(NREG));
      ready = (state_q == S_RUN);
      valA  = '0;
      valB  = '0;
      if (ready && ok_a) begin
         if (BYP && srcA == dstM_w)      valA = valM_w;
         else if (BYP && srcA == dstE_w) valA = valE_w;
         else                            valA = arr_a;
      end
      if (ready && ok_b) begin
         if (BYP && srcB == dstM_w)      valB = valM_w;
         else if (BYP && srcB == dstE_w) valB = valE_w;
         else                            valB = arr_b;
      end
   end

   // A busy source being written back this cycle is forwarded, so no hazard
   always_comb begin
      hazard_a = busy_a && !(BYP && (srcA == dstE_w || srcA == dstM_w));
      hazard_b = busy_b && !(BYP && (srcB == dstE_w || srcB == dstM_w));
      stall    = !ready || hazard_a || hazard_b;
   end

   // Init sequencer next state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_INIT: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LAST) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end
         end
         S_RUN:   state_d = S_RUN;
         default: state_d = S_INIT;
      endcase
   end

   // Scoreboard update: clears first, then issue sets, so set wins
   always_comb begin
      busy_d = busy_q;
      if (state_q == S_RUN) begin
         for (int i = 0; i < int'(NREG); i++) begin
            if (dstE_w == ID_W'(i) || dstM_w == ID_W'(i)) busy_d[i] = 1'b0;
         end
         if (issue && !stall) begin
            for (int i = 0; i < int'(NREG); i++) begin
               if (dstE == ID_W'(i) || dstM == ID_W'(i)) busy_d[i] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
         busy_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

   assign init_val = (INIT_MODE != 0) ? DATA_W'(cnt_q) : '0;

   // Register array without reset; M port has priority over E on the same ID
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(NREG); i++) begin
         if (state_q == S_INIT) begin
            if (cnt_q == ID_W'(i)) regs_q[i] <= init_val;
         end else if (dstM_w == ID_W'(i)) begin
            regs_q[i] <= valM_w;
         end else if (dstE_w == ID_W'(i)) begin
            regs_q[i] <= valE_w;
         end
      end
   end

endmodule
